// File: rtl/systolic_mem_pkg.sv
// ============================================================================
// Module  : systolic_mem_pkg
// Brief   : Shared types and helpers for the systolic-array BRAM responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_mem_pkg;

    // Default word geometry: ROWS lanes of WORD_SIZE bits each.
    localparam int c_ROWS      = 4;
    localparam int c_WORD_SIZE = 16;
    localparam int c_WORD_W    = c_ROWS * c_WORD_SIZE;

    // Widest word the parity helper accepts; narrower words are zero-extended,
    // which does not change their parity.
    localparam int c_PAR_MAX_W = 1024;

    // Host-side request FSM.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } host_state_t;

    // Even parity: returns the bit that makes the total count of ones even.
    function automatic logic parity_of(input logic [c_PAR_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage : systolic_mem_pkg

`default_nettype wire

// File: rtl/systolic_bram_responder_bram_core.sv
// ============================================================================
// Module  : bram_core
// Brief   : Word storage with a read-first registered array port (A) and a
//           combinational-read host port (B). Optional per-word parity bit
//           when PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_core
    import systolic_mem_pkg::*;
#(
    parameter int ROWS       = c_ROWS,
    parameter int WORD_SIZE  = c_WORD_SIZE,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_a_en,
    input  logic                      i_a_rst,
    input  logic                      i_a_we,
    input  logic [ADDR_WIDTH-1:0]     i_a_addr,
    input  logic [ROWS*WORD_SIZE-1:0] i_a_din,
    output logic [ROWS*WORD_SIZE-1:0] o_a_dout,
    input  logic                      i_b_we,
    input  logic [ADDR_WIDTH-1:0]     i_b_addr,
    input  logic [ROWS*WORD_SIZE-1:0] i_b_wdata,
    output logic [ROWS*WORD_SIZE-1:0] o_b_rdata
`ifdef PARITY_EN
    ,
    input  logic                      i_inject_par,
    output logic                      o_a_perr,
    output logic                      o_b_perr
`endif
);

    localparam int c_W     = ROWS * WORD_SIZE;
    localparam int c_DEPTH = 2 ** ADDR_WIDTH;

    logic [c_W-1:0]        r_mem [c_DEPTH];
    logic                  w_a_wr;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [c_W-1:0]        w_wr_data;

    // The two ports never write together: the host only gets the memory while
    // the array port is disabled, so one physical write path suffices.
    always_comb begin
        w_a_wr    = i_a_en & i_a_we;
        w_wr_en   = w_a_wr | i_b_we;
        w_wr_addr = w_a_wr ? i_a_addr : i_b_addr;
        w_wr_data = w_a_wr ? i_a_din  : i_b_wdata;
    end

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Array read port: registered, read-first, array-side clear wins over read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_a_dout <= '0;
        end else if (i_a_en) begin
            o_a_dout <= i_a_rst ? '0 : r_mem[i_a_addr];
        end
    end

    assign o_b_rdata = r_mem[i_b_addr];

`ifdef PARITY_EN
    logic r_par [c_DEPTH];

    // Stored parity bit, optionally inverted to provoke errors on purpose.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_par[w_wr_addr] <= parity_of(c_PAR_MAX_W'(w_wr_data)) ^ i_inject_par;
        end
    end

    // Array-side parity error, pulsed alongside the word it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_a_perr <= 1'b0;
        end else begin
            o_a_perr <= i_a_en & ~i_a_rst &
                        (parity_of(c_PAR_MAX_W'(r_mem[i_a_addr])) != r_par[i_a_addr]);
        end
    end

    assign o_b_perr = parity_of(c_PAR_MAX_W'(r_mem[i_b_addr])) != r_par[i_b_addr];
`endif

endmodule : bram_core

`default_nettype wire

// File: rtl/systolic_bram_responder.sv
// ============================================================================
// Module  : systolic_bram_responder
// Brief   : Memory-side responder for one systolic-array BRAM port. Serves the
//           array's we/addr/din/dout port (1-cycle read latency) and, while the
//           array does not own the memory, a host valid/ready preload/readback
//           port. Optional macro PARITY_EN adds per-word even parity with
//           inject_par / parity_err ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_bram_responder
    import systolic_mem_pkg::*;
#(
    parameter int ROWS       = c_ROWS,
    parameter int WORD_SIZE  = c_WORD_SIZE,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      bram_rst,
    input  logic                      array_active,
    input  logic                      bram_we,
    input  logic [ADDR_WIDTH-1:0]     bram_addr,
    input  logic [ROWS*WORD_SIZE-1:0] bram_din,
    output logic [ROWS*WORD_SIZE-1:0] bram_dout,
    input  logic                      host_valid,
    output logic                      host_ready,
    input  logic                      host_wr,
    input  logic [ADDR_WIDTH-1:0]     host_addr,
    input  logic [ROWS*WORD_SIZE-1:0] host_wdata,
    output logic                      host_rvalid,
    output logic [ROWS*WORD_SIZE-1:0] host_rdata,
    input  logic                      host_rready,
    output logic [ADDR_WIDTH:0]       wr_count
`ifdef PARITY_EN
    ,
    input  logic                      inject_par,
    output logic                      parity_err
`endif
);

    localparam int               c_W       = ROWS * WORD_SIZE;
    localparam logic [ADDR_WIDTH:0] c_CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    host_state_t    r_state;
    host_state_t    w_state_next;
    logic           w_accept;
    logic           w_host_wr_acc;
    logic           w_host_rd_acc;
    logic [c_W-1:0] w_b_rdata;

    assign host_ready    = ~array_active & (r_state == IDLE);
    assign w_accept      = host_valid & host_ready;
    assign w_host_wr_acc = w_accept & host_wr;
    assign w_host_rd_acc = w_accept & ~host_wr;
    // The response is valid exactly while the FSM waits in RESP.
    assign host_rvalid   = (r_state == RESP);

`ifdef PARITY_EN
    logic w_a_perr;
    logic w_b_perr;
    logic r_h_perr;
`endif

    bram_core #(
        .ROWS       (ROWS),
        .WORD_SIZE  (WORD_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk          (clk),
        .rst_n        (resetn),
        .i_a_en       (array_active),
        .i_a_rst      (bram_rst),
        .i_a_we       (bram_we),
        .i_a_addr     (bram_addr),
        .i_a_din      (bram_din),
        .o_a_dout     (bram_dout),
        .i_b_we       (w_host_wr_acc),
        .i_b_addr     (host_addr),
        .i_b_wdata    (host_wdata),
        .o_b_rdata    (w_b_rdata)
`ifdef PARITY_EN
        ,
        .i_inject_par (inject_par),
        .o_a_perr     (w_a_perr),
        .o_b_perr     (w_b_perr)
`endif
    );

    // Host FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Host FSM next state: reads park in RESP until the host takes the data.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_host_rd_acc) w_state_next = RESP;
            RESP:    if (host_rready)   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Read response data, captured on acceptance and held through the stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            host_rdata <= '0;
        end else if (w_host_rd_acc) begin
            host_rdata <= w_b_rdata;
        end
    end

    // Saturating count of accepted host writes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_count <= '0;
        end else if (w_host_wr_acc && (wr_count != c_CNT_MAX)) begin
            wr_count <= wr_count + 1'b1;
        end
    end

`ifdef PARITY_EN
    // Host-side parity error, pulsed on the first cycle of host_rvalid.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_h_perr <= 1'b0;
        end else begin
            r_h_perr <= w_host_rd_acc & w_b_perr;
        end
    end

    assign parity_err = w_a_perr | r_h_perr;
`endif

endmodule : systolic_bram_responder

`default_nettype wire

// File: tb/tb_systolic_bram_responder.sv
// ============================================================================
// Module  : tb_systolic_bram_responder
// Brief   : Self-checking bench: directed preload/readback/collision/reset
//           scenarios plus randomized traffic, checked against a word-level
//           memory model every cycle. Covers PARITY_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_bram_responder;

    localparam logic [63:0] c_BASE = 64'h0001_0002_0003_0004;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        bram_rst = 1'b0;
    logic        array_active = 1'b0;
    logic        bram_we = 1'b0;
    logic [1:0]  bram_addr = '0;
    logic [63:0] bram_din = '0;
    logic [63:0] bram_dout;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic        host_wr = 1'b0;
    logic [1:0]  host_addr = '0;
    logic [63:0] host_wdata = '0;
    logic        host_rvalid;
    logic [63:0] host_rdata;
    logic        host_rready = 1'b0;
    logic [2:0]  wr_count;
    logic        inject_par = 1'b0;
`ifdef PARITY_EN
    logic        parity_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    systolic_bram_responder #(
        .ROWS       (4),
        .WORD_SIZE  (16),
        .ADDR_WIDTH (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bram_rst     (bram_rst),
        .array_active (array_active),
        .bram_we      (bram_we),
        .bram_addr    (bram_addr),
        .bram_din     (bram_din),
        .bram_dout    (bram_dout),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_wr      (host_wr),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .host_rready  (host_rready),
        .wr_count     (wr_count)
`ifdef PARITY_EN
        ,
        .inject_par   (inject_par),
        .parity_err   (parity_err)
`endif
    );

    // ---------------- behavioural model (word-level memory + response slot)
    logic [63:0] m_mem [4];
    bit          m_known [4];
    bit          m_par [4];
    logic [63:0] e_dout = '0;
    bit          e_dout_known = 1'b1;
    logic [63:0] e_rdata = '0;
    bit          e_pending = 1'b0;
    int          e_cnt = 0;
    bit          e_perr = 1'b0;
    bit          m_host_ok;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_dout       = '0;
            e_dout_known = 1'b1;
            e_rdata      = '0;
            e_pending    = 1'b0;
            e_cnt        = 0;
            e_perr       = 1'b0;
        end else begin
            m_host_ok = !array_active && !e_pending;
            e_perr    = 1'b0;
            if (array_active) begin
                if (bram_rst) begin
                    e_dout       = '0;
                    e_dout_known = 1'b1;
                end else begin
                    e_dout       = m_mem[bram_addr];
                    e_dout_known = m_known[bram_addr];
                    e_perr       = m_known[bram_addr] && ((^m_mem[bram_addr]) != m_par[bram_addr]);
                end
                if (bram_we) begin
                    m_mem[bram_addr]   = bram_din;
                    m_known[bram_addr] = 1'b1;
                    m_par[bram_addr]   = (^bram_din) ^ inject_par;
                end
            end
            if (e_pending) begin
                if (host_rready) e_pending = 1'b0;
            end else if (host_valid && m_host_ok) begin
                if (host_wr) begin
                    m_mem[host_addr]   = host_wdata;
                    m_known[host_addr] = 1'b1;
                    m_par[host_addr]   = (^host_wdata) ^ inject_par;
                    if (e_cnt < 4) e_cnt = e_cnt + 1;
                end else begin
                    e_rdata   = m_mem[host_addr];
                    e_pending = 1'b1;
                    e_perr    = e_perr || ((^m_mem[host_addr]) != m_par[host_addr]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    task automatic compare_model();
        if (e_dout_known) check("bram_dout", bram_dout, e_dout);
        check("host_rvalid", 64'(host_rvalid), 64'(e_pending));
        check("host_rdata", host_rdata, e_rdata);
        check("host_ready", 64'(host_ready), 64'(!array_active && !e_pending));
        check("wr_count", 64'(wr_count), 64'(e_cnt));
`ifdef PARITY_EN
        check("parity_err", 64'(parity_err), 64'(e_perr));
`endif
    endtask

    // One clock: inputs were set at the previous negedge; compare at this one.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        // ---- reset
        cycle();
        cycle();
        check("rst_dout", bram_dout, 64'h0);
        check("rst_rvalid", 64'(host_rvalid), 64'h0);
        check("rst_rdata", host_rdata, 64'h0);
        check("rst_wr_count", 64'(wr_count), 64'h0);
        resetn = 1'b1;

        // ---- preload, back-to-back, 5th write saturates the count
        for (int i = 0; i < 5; i++) begin
            host_valid = 1'b1;
            host_wr    = 1'b1;
            host_addr  = 2'(i % 4);
            host_wdata = c_BASE + 64'(i % 4);
            check("preload_ready", 64'(host_ready), 64'h1);
            cycle();
        end
        host_valid = 1'b0;
        cycle();
        check("wr_count_sat", 64'(wr_count), 64'h4);

        // ---- readback of addr2 with a 3-cycle stall
        host_valid = 1'b1;
        host_wr    = 1'b0;
        host_addr  = 2'd2;
        cycle();
        host_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("stall_rvalid", 64'(host_rvalid), 64'h1);
            check("stall_rdata", host_rdata, 64'h0001_0002_0003_0006);
            check("stall_ready", 64'(host_ready), 64'h0);
            cycle();
        end
        host_rready = 1'b1;
        cycle();
        host_rready = 1'b0;
        check("post_hs_rvalid", 64'(host_rvalid), 64'h0);
        check("post_hs_ready", 64'(host_ready), 64'h1);

        // ---- array read latency, host locked out
        array_active = 1'b1;
        bram_addr    = 2'd1;
        host_valid   = 1'b1;
        cycle();
        check("array_rd", bram_dout, 64'h0001_0002_0003_0005);
        check("array_host_ready", 64'(host_ready), 64'h0);

        // ---- read-first collision
        bram_we   = 1'b1;
        bram_addr = 2'd3;
        bram_din  = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle();
        bram_we = 1'b0;
        check("collide_old", bram_dout, 64'h0001_0002_0003_0007);
        cycle();
        check("collide_new", bram_dout, 64'hFFFF_FFFF_FFFF_FFFF);

        // ---- array-side clear
        bram_rst  = 1'b1;
        bram_addr = 2'd0;
        cycle();
        check("bram_rst_dout", bram_dout, 64'h0);
        bram_rst   = 1'b0;
        host_valid = 1'b0;

        // ---- reset in the middle of a response
        array_active = 1'b0;
        host_valid   = 1'b1;
        host_wr      = 1'b0;
        host_addr    = 2'd1;
        cycle();
        host_valid = 1'b0;
        check("resp_rvalid", 64'(host_rvalid), 64'h1);
        check("resp_rdata", host_rdata, 64'h0001_0002_0003_0005);
        #1 resetn = 1'b0;
        #1;
        check("async_rvalid", 64'(host_rvalid), 64'h0);
        check("async_ready", 64'(host_ready), 64'h1);
        check("async_wr_count", 64'(wr_count), 64'h0);
        cycle();
        resetn = 1'b1;

        // ---- randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) array_active = ~array_active;
            bram_we     = 1'($urandom_range(0, 1));
            bram_rst    = ($urandom_range(0, 15) == 0);
            bram_addr   = 2'($urandom_range(0, 3));
            bram_din    = {$urandom, $urandom};
            host_valid  = 1'($urandom_range(0, 1));
            host_wr     = 1'($urandom_range(0, 1));
            host_addr   = 2'($urandom_range(0, 3));
            host_wdata  = {$urandom, $urandom};
            host_rready = 1'($urandom_range(0, 1));
            cycle();
        end

`ifdef PARITY_EN
        // ---- parity: corrupt addr0, then read it and a clean address
        array_active = 1'b0;
        bram_we      = 1'b0;
        bram_rst     = 1'b0;
        host_valid   = 1'b0;
        host_rready  = 1'b1;
        cycle();
        cycle();
        host_rready = 1'b0;
        host_valid  = 1'b1;
        host_wr     = 1'b1;
        host_addr   = 2'd0;
        host_wdata  = 64'h0000_0000_0000_0003;
        inject_par  = 1'b1;
        cycle();
        inject_par   = 1'b0;
        host_valid   = 1'b0;
        array_active = 1'b1;
        bram_addr    = 2'd0;
        cycle();
        check("par_err_hit", 64'(parity_err), 64'h1);
        check("par_err_dout", bram_dout, 64'h0000_0000_0000_0003);
        bram_addr = 2'd1;
        cycle();
        check("par_err_clean", 64'(parity_err), 64'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_systolic_bram_responder

`default_nettype wire
